reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 18 +
 rtl/reorder_buffer_if.sv | 53 +++++
 rtl/reorder_buffer.sv | 138 +++++++++++++
 tb/tb_reorder_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB/register/data types and constants used across the ROB slice.
package reorder_buffer_pkg;

    localparam int ROB_ID_WIDTH  = 4;
    localparam int REG_POS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    typedef logic [ROB_ID_WIDTH-1:0]  ROB_ID_TYPE;
    typedef logic [REG_POS_WIDTH-1:0] REG_POS_TYPE;
    typedef logic [DATA_WIDTH-1:0]    DATA_TYPE;

    localparam ROB_ID_TYPE  ZERO_ROB  = '0;
    localparam REG_POS_TYPE ZERO_REG  = '0;
    localparam DATA_TYPE    ZERO_WORD = '0;
    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatcher, CDB, register-file and fetch-redirect signals of the reorder buffer.
interface reorder_buffer_if #(parameter int ROB_ID_W = 4);
    import reorder_buffer_pkg::*;

    logic                ena_from_dsp;
    REG_POS_TYPE         rd_from_dsp;
    logic                is_jump_from_dsp;
    logic                pred_jump_from_dsp;
    logic [ROB_ID_W-1:0] alloc_id_to_dsp;
    logic                full_to_dsp;

    logic [ROB_ID_W-1:0] Q1_from_dsp;
    logic [ROB_ID_W-1:0] Q2_from_dsp;
    logic                ready1_to_dsp;
    logic                ready2_to_dsp;
    DATA_TYPE            V1_to_dsp;
    DATA_TYPE            V2_to_dsp;

    logic                valid_from_cdb;
    logic [ROB_ID_W-1:0] rob_id_from_cdb;
    DATA_TYPE            V_from_cdb;
    logic                jump_from_cdb;
    DATA_TYPE            target_pc_from_cdb;

    logic                commit_flag_to_reg;
    REG_POS_TYPE         rd_to_reg;
    logic [ROB_ID_W-1:0] Q_to_reg;
    DATA_TYPE            V_to_reg;

    logic                rollback_flag_to_all;
    DATA_TYPE            target_pc_to_if;

    modport master (
        output ena_from_dsp, rd_from_dsp, is_jump_from_dsp, pred_jump_from_dsp,
        output Q1_from_dsp, Q2_from_dsp,
        output valid_from_cdb, rob_id_from_cdb, V_from_cdb, jump_from_cdb, target_pc_from_cdb,
        input  alloc_id_to_dsp, full_to_dsp,
        input  ready1_to_dsp, ready2_to_dsp, V1_to_dsp, V2_to_dsp,
        input  commit_flag_to_reg, rd_to_reg, Q_to_reg, V_to_reg,
        input  rollback_flag_to_all, target_pc_to_if
    );

    modport slave (
        input  ena_from_dsp, rd_from_dsp, is_jump_from_dsp, pred_jump_from_dsp,
        input  Q1_from_dsp, Q2_from_dsp,
        input  valid_from_cdb, rob_id_from_cdb, V_from_cdb, jump_from_cdb, target_pc_from_cdb,
        output alloc_id_to_dsp, full_to_dsp,
        output ready1_to_dsp, ready2_to_dsp, V1_to_dsp, V2_to_dsp,
        output commit_flag_to_reg, rd_to_reg, Q_to_reg, V_to_reg,
        output rollback_flag_to_all, target_pc_to_if
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/commit, CDB completion, operand
// forwarding and branch-mispredict flush. Slot 0 is reserved as "no producer".
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = 16,
    parameter int ROB_ID_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);

    typedef logic [ROB_ID_W-1:0] id_t;

    localparam id_t FIRST_ID   = id_t'(1);
    localparam id_t LAST_ID    = id_t'(ROB_SIZE - 1);
    localparam id_t FULL_COUNT = id_t'(ROB_SIZE - 1);

    id_t         head;
    id_t         tail;
    id_t         count;

    logic        busy_q    [ROB_SIZE];
    logic        ready_q   [ROB_SIZE];
    logic        is_jump_q [ROB_SIZE];
    logic        pred_q    [ROB_SIZE];
    logic        jump_q    [ROB_SIZE];
    REG_POS_TYPE rd_q      [ROB_SIZE];
    DATA_TYPE    v_q       [ROB_SIZE];
    DATA_TYPE    tpc_q     [ROB_SIZE];

    logic        full;
    logic        alloc_ok;
    logic        cdb_ok;
    logic        commit_ok;
    logic        mispredict;
    id_t         cdb_id;

    function automatic id_t next_id(id_t id);
        return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
    endfunction

    assign cdb_id     = rob.rob_id_from_cdb;
    assign full       = (count == FULL_COUNT);
    assign alloc_ok   = rob.ena_from_dsp && !full;
    assign cdb_ok     = rob.valid_from_cdb && (cdb_id != '0) && busy_q[cdb_id];
    assign commit_ok  = (count != '0) && ready_q[head];
    assign mispredict = commit_ok && is_jump_q[head] && (jump_q[head] != pred_q[head]);

    assign rob.full_to_dsp     = full;
    assign rob.alloc_id_to_dsp = tail;

    // Operand lookup forwards a same-cycle CDB broadcast ahead of the stored copy.
    assign {rob.ready1_to_dsp, rob.V1_to_dsp} =
        (rob.Q1_from_dsp == '0) ? {TRUE, ZERO_WORD} :
        (rob.valid_from_cdb && cdb_id == rob.Q1_from_dsp) ? {TRUE, rob.V_from_cdb} :
        {ready_q[rob.Q1_from_dsp], v_q[rob.Q1_from_dsp]};

    assign {rob.ready2_to_dsp, rob.V2_to_dsp} =
        (rob.Q2_from_dsp == '0) ? {TRUE, ZERO_WORD} :
        (rob.valid_from_cdb && cdb_id == rob.Q2_from_dsp) ? {TRUE, rob.V_from_cdb} :
        {ready_q[rob.Q2_from_dsp], v_q[rob.Q2_from_dsp]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= FIRST_ID;
            tail  <= FIRST_ID;
            count <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= FALSE;
                ready_q[i] <= FALSE;
            end
        end else if (mispredict) begin
            head  <= FIRST_ID;
            tail  <= FIRST_ID;
            count <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= FALSE;
                ready_q[i] <= FALSE;
            end
        end else begin
            if (alloc_ok) begin
                busy_q[tail]  <= TRUE;
                ready_q[tail] <= FALSE;
                tail          <= next_id(tail);
            end
            if (cdb_ok) begin
                ready_q[cdb_id] <= TRUE;
            end
            // Retire last so a same-edge CDB hit on the head cannot re-arm it.
            if (commit_ok) begin
                busy_q[head]  <= FALSE;
                ready_q[head] <= FALSE;
                head          <= next_id(head);
            end
            case ({alloc_ok, commit_ok})
                2'b10:   count <= count + FIRST_ID;
                2'b01:   count <= count - FIRST_ID;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!mispredict) begin
            if (alloc_ok) begin
                rd_q[tail]      <= rob.rd_from_dsp;
                is_jump_q[tail] <= rob.is_jump_from_dsp;
                pred_q[tail]    <= rob.pred_jump_from_dsp;
            end
            if (cdb_ok) begin
                v_q[cdb_id]    <= rob.V_from_cdb;
                jump_q[cdb_id] <= rob.jump_from_cdb;
                tpc_q[cdb_id]  <= rob.target_pc_from_cdb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob.commit_flag_to_reg   <= FALSE;
            rob.rd_to_reg            <= ZERO_REG;
            rob.Q_to_reg             <= '0;
            rob.V_to_reg             <= ZERO_WORD;
            rob.rollback_flag_to_all <= FALSE;
            rob.target_pc_to_if      <= ZERO_WORD;
        end else begin
            rob.commit_flag_to_reg   <= commit_ok;
            rob.rd_to_reg            <= commit_ok ? rd_q[head] : ZERO_REG;
            rob.Q_to_reg             <= commit_ok ? head : '0;
            rob.V_to_reg             <= commit_ok ? v_q[head] : ZERO_WORD;
            rob.rollback_flag_to_all <= mispredict;
            rob.target_pc_to_if      <= mispredict ? tpc_q[head] : ZERO_WORD;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations are queued in program order
// and every cycle's commit/rollback output is compared against the queue head.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_ID_W(4)) rob_bus ();

    reorder_buffer #(.ROB_SIZE(16), .ROB_ID_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_bus)
    );

    typedef struct {
        logic [3:0] id;
        logic [4:0] rd;
    } pend_t;

    pend_t       sb[$];
    logic        m_ready [16];
    logic        m_isj   [16];
    logic        m_pred  [16];
    logic        m_act   [16];
    logic [31:0] m_v     [16];
    logic [31:0] m_tpc   [16];
    logic [3:0]  m_tail;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] id);
        return (id == 4'd15) ? 4'd1 : id + 4'd1;
    endfunction

    function automatic bit in_sb(input logic [3:0] id);
        foreach (sb[i]) if (sb[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_tail = 4'd1;
        for (int i = 0; i < 16; i++) m_ready[i] = 1'b0;
    endtask

    // One clock: drive inputs, check combinational outputs, clock, check commit port, advance model.
    task automatic cycle(input logic ena, input logic [4:0] rd, input logic isj, input logic pred,
                         input logic cv, input logic [3:0] cid, input logic [31:0] cval,
                         input logic cj, input logic [31:0] ctpc,
                         input logic [3:0] q1, input logic [3:0] q2);
        bit          full_exp, accept, occ, exp_commit, exp_rb, r1, r2;
        pend_t       h;
        logic [31:0] v1, v2;
        rob_bus.ena_from_dsp       = ena;
        rob_bus.rd_from_dsp        = rd;
        rob_bus.is_jump_from_dsp   = isj;
        rob_bus.pred_jump_from_dsp = pred;
        rob_bus.valid_from_cdb     = cv;
        rob_bus.rob_id_from_cdb    = cid;
        rob_bus.V_from_cdb         = cval;
        rob_bus.jump_from_cdb      = cj;
        rob_bus.target_pc_from_cdb = ctpc;
        rob_bus.Q1_from_dsp        = q1;
        rob_bus.Q2_from_dsp        = q2;
        #1;
        full_exp = (sb.size() == 15);
        check("full", rob_bus.full_to_dsp, full_exp);
        check("alloc_id", rob_bus.alloc_id_to_dsp, m_tail);
        r1 = (q1 == 0) || m_ready[q1] || (cv && cid == q1);
        r2 = (q2 == 0) || m_ready[q2] || (cv && cid == q2);
        v1 = (q1 == 0) ? 32'h0 : (cv && cid == q1) ? cval : m_v[q1];
        v2 = (q2 == 0) ? 32'h0 : (cv && cid == q2) ? cval : m_v[q2];
        check("ready1", rob_bus.ready1_to_dsp, r1);
        check("ready2", rob_bus.ready2_to_dsp, r2);
        if (r1) check("V1", rob_bus.V1_to_dsp, v1);
        if (r2) check("V2", rob_bus.V2_to_dsp, v2);

        exp_commit = 1'b0;
        exp_rb     = 1'b0;
        if (sb.size() > 0) begin
            h          = sb[0];
            exp_commit = m_ready[h.id];
            exp_rb     = exp_commit && m_isj[h.id] && (m_act[h.id] != m_pred[h.id]);
        end
        accept = ena && !full_exp;
        occ    = cv && (cid != 0) && in_sb(cid);

        @(posedge clk);
        #1;
        check("commit_flag", rob_bus.commit_flag_to_reg, exp_commit);
        if (exp_commit) begin
            check("commit_rd", rob_bus.rd_to_reg, h.rd);
            check("commit_Q", rob_bus.Q_to_reg, h.id);
            check("commit_V", rob_bus.V_to_reg, m_v[h.id]);
        end
        check("rollback", rob_bus.rollback_flag_to_all, exp_rb);
        if (exp_rb) check("target_pc", rob_bus.target_pc_to_if, m_tpc[h.id]);

        if (exp_rb) begin
            model_reset();
        end else begin
            if (accept) begin
                sb.push_back('{id: m_tail, rd: rd});
                m_ready[m_tail] = 1'b0;
                m_isj[m_tail]   = isj;
                m_pred[m_tail]  = pred;
                m_tail          = nxt(m_tail);
            end
            if (occ) begin
                m_ready[cid] = 1'b1;
                m_v[cid]     = cval;
                m_act[cid]   = cj;
                m_tpc[cid]   = ctpc;
            end
            if (exp_commit) begin
                m_ready[h.id] = 1'b0;
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic alloc(input logic [4:0] rd, input logic isj, input logic pred);
        cycle(1'b1, rd, isj, pred, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd0, 4'd0);
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic j, input logic [31:0] tpc);
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, id, v, j, tpc, 4'd0, 4'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd0, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_commit_flag"}, rob_bus.commit_flag_to_reg, 1'b0);
        check({tag, "_rd"}, rob_bus.rd_to_reg, 5'd0);
        check({tag, "_Q"}, rob_bus.Q_to_reg, 4'd0);
        check({tag, "_V"}, rob_bus.V_to_reg, 32'h0);
        check({tag, "_rollback"}, rob_bus.rollback_flag_to_all, 1'b0);
        check({tag, "_target_pc"}, rob_bus.target_pc_to_if, 32'h0);
        check({tag, "_full"}, rob_bus.full_to_dsp, 1'b0);
        check({tag, "_alloc_id"}, rob_bus.alloc_id_to_dsp, 4'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rob_bus.ena_from_dsp       = 1'b0;
        rob_bus.rd_from_dsp        = '0;
        rob_bus.is_jump_from_dsp   = 1'b0;
        rob_bus.pred_jump_from_dsp = 1'b0;
        rob_bus.valid_from_cdb     = 1'b0;
        rob_bus.rob_id_from_cdb    = '0;
        rob_bus.V_from_cdb         = '0;
        rob_bus.jump_from_cdb      = 1'b0;
        rob_bus.target_pc_from_cdb = '0;
        rob_bus.Q1_from_dsp        = '0;
        rob_bus.Q2_from_dsp        = '0;
        for (int i = 0; i < 16; i++) begin
            m_isj[i] = 1'b0; m_pred[i] = 1'b0; m_act[i] = 1'b0;
            m_v[i]   = '0;   m_tpc[i]  = '0;
        end
        do_reset("por");

        // Three allocations, then out-of-order completion with in-order retirement.
        alloc(5'd1, 1'b0, 1'b0);
        alloc(5'd2, 1'b0, 1'b0);
        alloc(5'd3, 1'b0, 1'b0);
        check("three_alloc_next_id", rob_bus.alloc_id_to_dsp, 4'd4);
        check("three_alloc_full", rob_bus.full_to_dsp, 1'b0);
        cdb(4'd2, 32'h22, 1'b0, 32'h0);
        cdb(4'd1, 32'h11, 1'b0, 32'h0);
        idle();
        idle();
        cdb(4'd3, 32'h33, 1'b0, 32'h0);
        idle();
        idle();

        // Correct jump (id 4), mispredicted jump (id 5), younger entry 6 flushed.
        alloc(5'd8, 1'b1, 1'b1);
        alloc(5'd7, 1'b1, 1'b0);
        alloc(5'd10, 1'b0, 1'b0);
        cdb(4'd4, 32'h44, 1'b1, 32'h200);
        cdb(4'd5, 32'h55, 1'b1, 32'h100);
        cycle(1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 4'd6, 32'h66, 1'b0, 32'h0, 4'd0, 4'd0);
        check("post_flush_alloc_id", rob_bus.alloc_id_to_dsp, 4'd1);
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd6, 4'd5);

        // Fill to 15 from id 1, then a refused 16th request.
        for (int i = 0; i < 15; i++) alloc(5'(i + 1), 1'b0, 1'b0);
        check("fill_full", rob_bus.full_to_dsp, 1'b1);
        alloc(5'd20, 1'b0, 1'b0);
        check("full_refused_id", rob_bus.alloc_id_to_dsp, 4'd1);

        // Operand forwarding and the id-0 query.
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd5, 32'hAB, 1'b0, 32'h0, 4'd5, 4'd0);
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd5, 4'd6);

        // Full with a same-edge commit still refuses; then wrap to id 1 and allocate+commit together.
        cdb(4'd1, 32'h101, 1'b0, 32'h0);
        alloc(5'd21, 1'b0, 1'b0);
        cdb(4'd2, 32'h202, 1'b0, 32'h0);
        check("wrap_alloc_id", rob_bus.alloc_id_to_dsp, 4'd1);
        alloc(5'd22, 1'b0, 1'b0);
        check("alloc_commit_id", rob_bus.alloc_id_to_dsp, 4'd2);
        check("alloc_commit_full", rob_bus.full_to_dsp, 1'b0);
        alloc(5'd23, 1'b0, 1'b0);
        check("refill_full", rob_bus.full_to_dsp, 1'b1);

        // Asynchronous reset with six entries pending and a commit pulse on the port.
        do_reset("mid");
        for (int i = 0; i < 6; i++) alloc(5'(i + 11), 1'b0, 1'b0);
        cdb(4'd1, 32'hC0DE, 1'b0, 32'h0);
        idle();
        check("pre_reset_commit", rob_bus.commit_flag_to_reg, 1'b1);
        do_reset("async");
        alloc(5'd30, 1'b0, 1'b0);
        check("post_reset_next_id", rob_bus.alloc_id_to_dsp, 4'd2);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
